// File: rtl/sha1_pkg.sv
// Shared constants, register map and helpers for the SHA-1 controller and its round function.
package sha1_pkg;

    localparam logic [31:0] IV0 = 32'h6745_2301;
    localparam logic [31:0] IV1 = 32'hEFCD_AB89;
    localparam logic [31:0] IV2 = 32'h98BA_DCFE;
    localparam logic [31:0] IV3 = 32'h1032_5476;
    localparam logic [31:0] IV4 = 32'hC3D2_E1F0;

    localparam logic [31:0] K0 = 32'h5A82_7999;
    localparam logic [31:0] K1 = 32'h6ED9_EBA1;
    localparam logic [31:0] K2 = 32'h8F1B_BCDC;
    localparam logic [31:0] K3 = 32'hCA62_C1D6;

    // Word indices (byte address bits [7:2]) within the slave window
    localparam logic [5:0] REG_CTRL   = 6'h00;
    localparam logic [5:0] REG_STATUS = 6'h01;
    localparam logic [5:0] REG_H0     = 6'h20;
    localparam logic [5:0] REG_H4     = 6'h24;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        ADD
    } state_e;

    function automatic logic [31:0] rotl(input logic [31:0] x, input logic [4:0] n);
        return (x << n) | (x >> (6'd32 - {1'b0, n}));
    endfunction

endpackage

// File: rtl/sha1_round.sv
// One SHA-1 compression round: maps {a,b,c,d,e}, the round's schedule word and t to the next state.
module sha1_round
    import sha1_pkg::*;
(
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic [31:0] c_i,
    input  logic [31:0] d_i,
    input  logic [31:0] e_i,
    input  logic [31:0] w_i,
    input  logic [6:0]  t_i,
    output logic [31:0] a_o,
    output logic [31:0] b_o,
    output logic [31:0] c_o,
    output logic [31:0] d_o,
    output logic [31:0] e_o
);

    logic [31:0] f;
    logic [31:0] k;

    // Round-group selection: Ch, Parity, Maj, Parity
    always_comb begin
        f = 32'h0;
        k = K0;
        if (t_i < 7'd20) begin
            f = (b_i & c_i) | (~b_i & d_i);
            k = K0;
        end else if (t_i < 7'd40) begin
            f = b_i ^ c_i ^ d_i;
            k = K1;
        end else if (t_i < 7'd60) begin
            f = (b_i & c_i) | (b_i & d_i) | (c_i & d_i);
            k = K2;
        end else begin
            f = b_i ^ c_i ^ d_i;
            k = K3;
        end
    end

    assign a_o = rotl(a_i, 5'd5) + f + e_i + k + w_i;
    assign b_o = a_i;
    assign c_o = rotl(b_i, 5'd30);
    assign d_o = c_i;
    assign e_o = d_i;

endmodule

// File: rtl/sha1_ctrl.sv
// Wishbone-slave SHA-1 block engine: W file, chaining digest, 80-round sequencer and status/IRQ.
// Optional macro SHA1_CTRL_IRQ_EN implements the IRQ_EN bit and drives irq_o.
module sha1_ctrl
    import sha1_pkg::*;
#(
    parameter logic [31:0] BASE_ADR = 32'h3000_0000
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_ni,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_dat_i,
    input  logic [31:0] wbs_adr_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic        busy_o,
    output logic        irq_o
);

    state_e      state_q;
    logic        ack_q;
    logic [31:0] dat_q;
    logic [6:0]  t_q;
    logic [31:0] w_q [16];
    logic [31:0] h_q [5];
    logic [31:0] a_q, b_q, c_q, d_q, e_q;
    logic [31:0] a_d, b_d, c_d, d_d, e_d;
    logic        done_q;
    logic        err_q;
    logic        irqEn;

    logic        access, wrAcc, rdAcc, busy;
    logic        adrHit, isCtrl, isStatus, isW, isH;
    logic        cmdBits, badWrite, goInit, goStart;
    logic [5:0]  wordIdx;
    logic [31:0] rdata;
    logic        unusedAdr;

    assign access   = wbs_stb_i & wbs_cyc_i & ~ack_q;
    assign wrAcc    = access & wbs_we_i;
    assign rdAcc    = access & ~wbs_we_i;
    assign busy     = (state_q != IDLE);

    assign wordIdx  = wbs_adr_i[7:2];
    assign adrHit   = (wbs_adr_i[31:8] == BASE_ADR[31:8]);
    assign isCtrl   = adrHit && (wordIdx == REG_CTRL);
    assign isStatus = adrHit && (wordIdx == REG_STATUS);
    assign isW      = adrHit && (wordIdx[5:4] == 2'b01);
    assign isH      = adrHit && (wordIdx >= REG_H0) && (wordIdx <= REG_H4);
    assign unusedAdr = ^wbs_adr_i[1:0];

    // Command writes while the engine owns W/H are dropped and flagged rather than stalled
    assign cmdBits  = wbs_sel_i[0] & (wbs_dat_i[0] | wbs_dat_i[1]);
    assign badWrite = wrAcc & busy & (isW | (isCtrl & cmdBits));
    assign goInit   = wrAcc & ~busy & isCtrl & wbs_sel_i[0] & wbs_dat_i[1];
    assign goStart  = wrAcc & ~busy & isCtrl & wbs_sel_i[0] & wbs_dat_i[0];

    logic [3:0]  idx, idxM3, idxM8, idxM14;
    logic [31:0] wExp, wRound;

    assign idx    = t_q[3:0];
    assign idxM3  = idx + 4'd13;
    assign idxM8  = idx + 4'd8;
    assign idxM14 = idx + 4'd2;
    assign wExp   = rotl(w_q[idxM3] ^ w_q[idxM8] ^ w_q[idxM14] ^ w_q[idx], 5'd1);
    assign wRound = (t_q < 7'd16) ? w_q[idx] : wExp;

    sha1_round u_round (
        .a_i (a_q),
        .b_i (b_q),
        .c_i (c_q),
        .d_i (d_q),
        .e_i (e_q),
        .w_i (wRound),
        .t_i (t_q),
        .a_o (a_d),
        .b_o (b_d),
        .c_o (c_d),
        .d_o (d_d),
        .e_o (e_d)
    );

    always_comb begin
        rdata = 32'h0;
        if (isCtrl) begin
            rdata[2] = irqEn;
        end else if (isStatus) begin
            rdata = {29'h0, err_q, done_q, busy};
        end else if (isW) begin
            rdata = w_q[wordIdx[3:0]];
        end else if (isH) begin
            rdata = h_q[wordIdx[2:0]];
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q <= IDLE;
            ack_q   <= 1'b0;
            dat_q   <= 32'h0;
            t_q     <= 7'd0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            a_q     <= 32'h0;
            b_q     <= 32'h0;
            c_q     <= 32'h0;
            d_q     <= 32'h0;
            e_q     <= 32'h0;
            for (int i = 0; i < 16; i++) begin
                w_q[i] <= 32'h0;
            end
            h_q[0]  <= IV0;
            h_q[1]  <= IV1;
            h_q[2]  <= IV2;
            h_q[3]  <= IV3;
            h_q[4]  <= IV4;
        end else begin
            ack_q <= access;
            dat_q <= rdAcc ? rdata : 32'h0;

            if (badWrite) begin
                err_q <= 1'b1;
            end
            if (wrAcc && isStatus && wbs_sel_i[0]) begin
                if (wbs_dat_i[1]) done_q <= 1'b0;
                if (wbs_dat_i[2]) err_q  <= 1'b0;
            end
            if (wrAcc && isW && !busy) begin
                for (int i = 0; i < 4; i++) begin
                    if (wbs_sel_i[i]) w_q[wordIdx[3:0]][8*i +: 8] <= wbs_dat_i[8*i +: 8];
                end
            end

            // The ADD branch sets DONE after the W1C above, so a completion beats a same-cycle clear
            case (state_q)
                IDLE: begin
                    if (goInit) begin
                        h_q[0] <= IV0;
                        h_q[1] <= IV1;
                        h_q[2] <= IV2;
                        h_q[3] <= IV3;
                        h_q[4] <= IV4;
                    end
                    if (goStart) begin
                        a_q     <= goInit ? IV0 : h_q[0];
                        b_q     <= goInit ? IV1 : h_q[1];
                        c_q     <= goInit ? IV2 : h_q[2];
                        d_q     <= goInit ? IV3 : h_q[3];
                        e_q     <= goInit ? IV4 : h_q[4];
                        t_q     <= 7'd0;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    a_q <= a_d;
                    b_q <= b_d;
                    c_q <= c_d;
                    d_q <= d_d;
                    e_q <= e_d;
                    if (t_q >= 7'd16) begin
                        w_q[idx] <= wExp;
                    end
                    if (t_q == 7'd79) begin
                        t_q     <= 7'd0;
                        state_q <= ADD;
                    end else begin
                        t_q <= t_q + 7'd1;
                    end
                end
                ADD: begin
                    h_q[0]  <= h_q[0] + a_q;
                    h_q[1]  <= h_q[1] + b_q;
                    h_q[2]  <= h_q[2] + c_q;
                    h_q[3]  <= h_q[3] + d_q;
                    h_q[4]  <= h_q[4] + e_q;
                    done_q  <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef SHA1_CTRL_IRQ_EN
    logic irqEn_q;

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            irqEn_q <= 1'b0;
        end else if (wrAcc && isCtrl && wbs_sel_i[0] && !badWrite) begin
            irqEn_q <= wbs_dat_i[2];
        end
    end

    assign irqEn = irqEn_q;
    assign irq_o = done_q & irqEn_q;
`else
    assign irqEn = 1'b0;
    assign irq_o = 1'b0;
`endif

    assign wbs_ack_o = ack_q;
    assign wbs_dat_o = dat_q;
    assign busy_o    = busy;

endmodule

// File: tb/tb_sha1_ctrl.sv
// Scoreboard bench for sha1_ctrl: bus reads push expected data, a negedge monitor checks it on ack.
module tb_sha1_ctrl;

    localparam logic [31:0] BASE = 32'h3000_0000;
`ifdef SHA1_CTRL_IRQ_EN
    localparam logic [31:0] IRQ_BUILT = 32'd1;
`else
    localparam logic [31:0] IRQ_BUILT = 32'd0;
`endif

    logic        clk = 1'b0;
    logic        rstN;
    logic        stb, cyc, we;
    logic [3:0]  sel;
    logic [31:0] datI, adr;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;
    logic        busy_o, irq_o;

    int          compared = 0;
    int          mismatched = 0;
    int          busyCnt = 0;
    bit          pendRead = 1'b0;
    string       nameQ[$];
    logic [31:0] expQ[$];
    logic [31:0] msg [16];
    string       monName;
    logic [31:0] monExp;

    always #5 clk = ~clk;

    sha1_ctrl #(.BASE_ADR(BASE)) dut (
        .wb_clk_i  (clk),
        .wb_rst_ni (rstN),
        .wbs_stb_i (stb),
        .wbs_cyc_i (cyc),
        .wbs_we_i  (we),
        .wbs_sel_i (sel),
        .wbs_dat_i (datI),
        .wbs_adr_i (adr),
        .wbs_ack_o (wbs_ack_o),
        .wbs_dat_o (wbs_dat_o),
        .busy_o    (busy_o),
        .irq_o     (irq_o)
    );

    // Monitor: pops one expectation per read acknowledge
    always @(negedge clk) begin
        busyCnt = busyCnt + (busy_o ? 1 : 0);
        if (wbs_ack_o && pendRead) begin
            pendRead = 1'b0;
            compared++;
            if (expQ.size() == 0) begin
                mismatched++;
                $display("[TB] FAIL unexpected_read: got %08h, no expectation queued", wbs_dat_o);
            end else begin
                monName = nameQ.pop_front();
                monExp  = expQ.pop_front();
                if (wbs_dat_o !== monExp) begin
                    mismatched++;
                    $display("[TB] FAIL %s: got %08h expected %08h", monName, wbs_dat_o, monExp);
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input bit isWrite, input logic [7:0] off,
                                 input logic [31:0] data, input logic [3:0] lanes);
        bit got;
        @(negedge clk);
        pendRead = !isWrite;
        stb  = 1'b1;
        cyc  = 1'b1;
        we   = isWrite;
        adr  = BASE + {24'h0, off};
        datI = data;
        sel  = lanes;
        got  = 1'b0;
        for (int i = 0; i < 8 && !got; i++) begin
            @(negedge clk);
            if (wbs_ack_o) got = 1'b1;
        end
        stb = 1'b0;
        cyc = 1'b0;
        we  = 1'b0;
        if (!got) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL ack_timeout: offset %02h got no ack expected ack", off);
            if (!isWrite && expQ.size() > 0) begin
                pendRead = 1'b0;
                void'(nameQ.pop_front());
                void'(expQ.pop_front());
            end
        end
    endtask

    task automatic writeReg(input logic [7:0] off, input logic [31:0] data);
        applyStimulus(1'b1, off, data, 4'hF);
    endtask

    task automatic expectRead(input string name, input logic [7:0] off, input logic [31:0] exp);
        nameQ.push_back(name);
        expQ.push_back(exp);
        applyStimulus(1'b0, off, 32'h0, 4'hF);
    endtask

    task automatic checkDigest(input string tag, input logic [31:0] h0, input logic [31:0] h1,
                               input logic [31:0] h2, input logic [31:0] h3, input logic [31:0] h4);
        expectRead({tag, "_H0"}, 8'h80, h0);
        expectRead({tag, "_H1"}, 8'h84, h1);
        expectRead({tag, "_H2"}, 8'h88, h2);
        expectRead({tag, "_H3"}, 8'h8C, h3);
        expectRead({tag, "_H4"}, 8'h90, h4);
    endtask

    task automatic loadBlock();
        for (int i = 0; i < 16; i++) begin
            writeReg(8'h40 + 8'(i * 4), msg[i]);
        end
    endtask

    task automatic startRun(input logic [31:0] ctrl);
        busyCnt = 0;
        writeReg(8'h00, ctrl);
    endtask

    task automatic waitDone(input string tag);
        int n;
        n = 0;
        while (busy_o && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (busy_o) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL %s_timeout: busy still 1 expected 0", tag);
        end
        checkOutput({tag, "_busy_cycles"}, 32'(busyCnt), 32'd81);
    endtask

    task automatic setAbc();
        for (int i = 0; i < 16; i++) msg[i] = 32'h0;
        msg[0]  = 32'h6162_6380;
        msg[15] = 32'h0000_0018;
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rstN = 1'b0;
        stb  = 1'b0;
        cyc  = 1'b0;
        we   = 1'b0;
        sel  = 4'h0;
        datI = 32'h0;
        adr  = 32'h0;
        repeat (3) @(negedge clk);
        checkOutput("rst_busy", {31'h0, busy_o}, 32'd0);
        checkOutput("rst_irq", {31'h0, irq_o}, 32'd0);
        checkOutput("rst_ack", {31'h0, wbs_ack_o}, 32'd0);
        checkOutput("rst_dat", wbs_dat_o, 32'd0);
        rstN = 1'b1;

        $display("[TB] reset register sweep");
        checkDigest("iv", 32'h67452301, 32'hefcdab89, 32'h98badcfe, 32'h10325476, 32'hc3d2e1f0);
        expectRead("status_rst", 8'h04, 32'h0);
        expectRead("ctrl_rst", 8'h00, 32'h0);
        expectRead("w0_rst", 8'h40, 32'h0);
        expectRead("unmapped_rd", 8'h20, 32'h0);
        applyStimulus(1'b1, 8'h54, 32'hFFFF_FFFF, 4'b0010);
        expectRead("w5_byte_lane", 8'h54, 32'h0000_FF00);
        writeReg(8'h54, 32'h0);
        writeReg(8'hA0, 32'hDEAD_BEEF);
        expectRead("unmapped_wr", 8'hA0, 32'h0);

        $display("[TB] abc block");
        writeReg(8'h00, 32'h2);
        setAbc();
        loadBlock();
        startRun(32'h1);
        waitDone("abc");
        expectRead("abc_status", 8'h04, 32'h2);
        checkDigest("abc", 32'ha9993e36, 32'h4706816a, 32'hba3e2571, 32'h7850c26c, 32'h9cd0d89d);

        $display("[TB] empty message with INIT+START");
        writeReg(8'h04, 32'h2);
        expectRead("done_clear", 8'h04, 32'h0);
        for (int i = 0; i < 16; i++) msg[i] = 32'h0;
        msg[0] = 32'h8000_0000;
        loadBlock();
        startRun(32'h3);
        waitDone("empty");
        expectRead("empty_status", 8'h04, 32'h2);
        checkDigest("empty", 32'hda39a3ee, 32'h5e6b4b0d, 32'h3255bfef, 32'h95601890, 32'hafd80709);

        $display("[TB] two-block chain");
        msg = '{32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
        loadBlock();
        startRun(32'h3);
        waitDone("blk1");
        for (int i = 0; i < 16; i++) msg[i] = 32'h0;
        msg[15] = 32'h0000_01C0;
        loadBlock();
        startRun(32'h1);
        waitDone("blk2");
        checkDigest("chain", 32'h84983e44, 32'h1c3bd26e, 32'hbaae4aa1, 32'hf95129e5, 32'he54670f1);

        $display("[TB] accesses while busy");
        writeReg(8'h04, 32'h2);
        writeReg(8'h00, 32'h2);
        setAbc();
        loadBlock();
        startRun(32'h1);
        writeReg(8'h4C, 32'h1234_5678);
        writeReg(8'h00, 32'h1);
        expectRead("status_err", 8'h04, 32'h5);
        expectRead("h0_busy", 8'h80, 32'h67452301);
        writeReg(8'h04, 32'h4);
        expectRead("status_errclr", 8'h04, 32'h1);
        writeReg(8'h00, 32'h4);
        expectRead("ctrl_irqen", 8'h00, IRQ_BUILT << 2);
        expectRead("status_irqwr", 8'h04, 32'h1);
        waitDone("busyrun");
        checkOutput("irq_done", {31'h0, irq_o}, IRQ_BUILT);
        expectRead("busyrun_status", 8'h04, 32'h2);
        checkDigest("busyrun", 32'ha9993e36, 32'h4706816a, 32'hba3e2571, 32'h7850c26c, 32'h9cd0d89d);
        writeReg(8'h04, 32'h2);
        checkOutput("irq_clr", {31'h0, irq_o}, 32'd0);

        $display("[TB] reset mid-run");
        startRun(32'h3);
        repeat (40) @(negedge clk);
        checkOutput("busy_mid", {31'h0, busy_o}, 32'd1);
        rstN = 1'b0;
        #1;
        checkOutput("abort_busy", {31'h0, busy_o}, 32'd0);
        checkOutput("abort_irq", {31'h0, irq_o}, 32'd0);
        checkOutput("abort_ack", {31'h0, wbs_ack_o}, 32'd0);
        checkOutput("abort_dat", wbs_dat_o, 32'd0);
        @(negedge clk);
        rstN = 1'b1;
        checkDigest("abort", 32'h67452301, 32'hefcdab89, 32'h98badcfe, 32'h10325476, 32'hc3d2e1f0);
        expectRead("abort_status", 8'h04, 32'h0);
        expectRead("abort_ctrl", 8'h00, 32'h0);
        expectRead("abort_w0", 8'h40, 32'h0);

        repeat (3) @(negedge clk);
        if (expQ.size() != 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL scoreboard_drain: %0d left expected 0", expQ.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
